// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : UART receive buffer. Operates either as a 16-entry FIFO
//                (fifo_en=1) or as a single holding register (fifo_en=0).
//                Each entry holds {data[7:0], parity_error, frame_error}.
//                Produces line-status bits (dr, oe, pe, fe, rx_fifo_error),
//                the fill level and data-available / char-timeout requests.
//  Ports       : pclk, preset          clock, synchronous active-high reset
//                rx_push, rsr_data,    completed character from the receiver
//                parity_error,
//                frame_error
//                fifo_en, fifo_clr,    mode select, storage clear, trigger
//                rtl                   level (1/4/8/14)
//                rbr_rd, lsr_rd        head pop, line-status read strobe
//                char_tick             character-time pulse (timeout build)
//                rbr_data, dr, oe,     head data and line-status outputs
//                pe, fe, rx_fifo_error
//                rx_level              entries held, 0..16
//                rda_int, cti_int      interrupt requests
//  Options     : UART_RX_TIMEOUT_EN    compiles in the character timeout
//                                      counter that drives cti_int
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_fifo (
  input  logic       pclk,
  input  logic       preset,
  input  logic       rx_push,
  input  logic [7:0] rsr_data,
  input  logic       parity_error,
  input  logic       frame_error,
  input  logic       fifo_en,
  input  logic       fifo_clr,
  input  logic [1:0] rtl,
  input  logic       rbr_rd,
  input  logic       lsr_rd,
  input  logic       char_tick,
  output logic [7:0] rbr_data,
  output logic       dr,
  output logic       oe,
  output logic       pe,
  output logic       fe,
  output logic       rx_fifo_error,
  output logic [4:0] rx_level,
  output logic       rda_int,
  output logic       cti_int
);

  // Entry layout: [9:2] data, [1] parity error, [0] frame error
  logic [9:0] mem_q [16];

  logic [3:0] wr_ptr_q, wr_ptr_d;
  logic [3:0] rd_ptr_q, rd_ptr_d;
  logic [4:0] level_q,  level_d;
  logic [4:0] err_cnt_q, err_cnt_d;
  logic       oe_q,     oe_d;
  logic       rda_q,    rda_d;
  logic       fifo_en_q;

  logic       w_empty;
  logic       w_full;
  logic       w_clr;
  logic       w_pop;
  logic       w_push_ok;
  logic       w_ovr;
  logic       w_overwrite;
  logic [9:0] w_head;
  logic [9:0] w_new_entry;
  logic       w_new_err;
  logic       w_head_err;
  logic [4:0] w_trig;

  assign w_head      = mem_q[rd_ptr_q];
  assign w_new_entry = {rsr_data, parity_error, frame_error};
  assign w_new_err   = parity_error | frame_error;
  assign w_head_err  = w_head[1] | w_head[0];

  always_comb begin
    w_empty = (level_q == 5'd0);
    // Holding mode has an effective depth of one entry
    w_full  = fifo_en ? (level_q == 5'd16) : (level_q != 5'd0);
    // A mode switch flushes storage exactly like an explicit clear
    w_clr   = fifo_clr | (fifo_en ^ fifo_en_q);
    w_pop   = rbr_rd & ~w_empty;
    // A same-cycle pop frees a slot, so a push at full is still accepted
    w_push_ok   = rx_push & (~w_full | w_pop);
    w_ovr       = rx_push & w_full & ~w_pop & ~w_clr;
    w_overwrite = w_ovr & ~fifo_en;
  end

  always_comb begin
    unique case (rtl)
      2'b00:   w_trig = 5'd1;
      2'b01:   w_trig = 5'd4;
      2'b10:   w_trig = 5'd8;
      default: w_trig = 5'd14;
    endcase
    if (!fifo_en) w_trig = 5'd1;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    err_cnt_d = err_cnt_q;
    oe_d      = oe_q;

    if (w_clr) begin
      wr_ptr_d  = 4'd0;
      rd_ptr_d  = 4'd0;
      level_d   = 5'd0;
      err_cnt_d = 5'd0;
    end else begin
      if (w_push_ok) wr_ptr_d = wr_ptr_q + 4'd1;
      if (w_pop)     rd_ptr_d = rd_ptr_q + 4'd1;
      level_d   = level_q + {4'd0, w_push_ok} - {4'd0, w_pop};
      err_cnt_d = err_cnt_q + {4'd0, w_push_ok & w_new_err}
                            - {4'd0, w_pop & w_head_err};
      // Holding-mode overwrite replaces the head entry and its error flags
      if (w_overwrite)
        err_cnt_d = err_cnt_q - {4'd0, w_head_err} + {4'd0, w_new_err};
    end

    // A new overrun wins over a concurrent line-status read
    if (w_ovr)       oe_d = 1'b1;
    else if (lsr_rd) oe_d = 1'b0;

    rda_d = (level_d >= w_trig);
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      wr_ptr_q  <= 4'd0;
      rd_ptr_q  <= 4'd0;
      level_q   <= 5'd0;
      err_cnt_q <= 5'd0;
      oe_q      <= 1'b0;
      rda_q     <= 1'b0;
      fifo_en_q <= fifo_en;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      err_cnt_q <= err_cnt_d;
      oe_q      <= oe_d;
      rda_q     <= rda_d;
      fifo_en_q <= fifo_en;
    end
  end

  // Storage carries no reset; empty state is masked at the outputs
  always_ff @(posedge pclk) begin
    if (!preset && !w_clr) begin
      if (w_push_ok)        mem_q[wr_ptr_q] <= w_new_entry;
      else if (w_overwrite) mem_q[rd_ptr_q] <= w_new_entry;
    end
  end

  assign dr            = ~w_empty;
  assign rbr_data      = dr ? w_head[9:2] : 8'h00;
  assign pe            = w_head[1] & dr;
  assign fe            = w_head[0] & dr;
  assign oe            = oe_q;
  assign rx_fifo_error = fifo_en & (err_cnt_q != 5'd0);
  assign rx_level      = level_q;
  assign rda_int       = rda_q;

`ifdef UART_RX_TIMEOUT_EN
  logic [2:0] tmo_q, tmo_d;
  logic       cti_q, cti_d;

  always_comb begin
    tmo_d = tmo_q;
    if (rx_push | rbr_rd | w_clr | w_empty)
      tmo_d = 3'd0;
    else if (char_tick && (tmo_q != 3'd4))
      tmo_d = tmo_q + 3'd1;
    cti_d = fifo_en & (level_d != 5'd0) & (tmo_d == 3'd4);
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      tmo_q <= 3'd0;
      cti_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      cti_q <= cti_d;
    end
  end

  assign cti_int = cti_q;
`else
  logic w_unused_char_tick;
  assign w_unused_char_tick = char_tick;
  assign cti_int = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Self-checking bench for uart_rx_fifo. A queue holds the
//                entries the buffer is expected to contain; pops compare the
//                DUT head against the queue front.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;

  logic       pclk = 1'b0;
  logic       preset, rx_push, parity_error, frame_error;
  logic [7:0] rsr_data;
  logic       fifo_en, fifo_clr, rbr_rd, lsr_rd, char_tick;
  logic [1:0] rtl;
  logic [7:0] rbr_data;
  logic       dr, oe, pe, fe, rx_fifo_error, rda_int, cti_int;
  logic [4:0] rx_level;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] sb[$];
  logic       exp_oe = 1'b0;

  uart_rx_fifo dut (
    .pclk(pclk), .preset(preset), .rx_push(rx_push), .rsr_data(rsr_data),
    .parity_error(parity_error), .frame_error(frame_error),
    .fifo_en(fifo_en), .fifo_clr(fifo_clr), .rtl(rtl), .rbr_rd(rbr_rd),
    .lsr_rd(lsr_rd), .char_tick(char_tick), .rbr_data(rbr_data), .dr(dr),
    .oe(oe), .pe(pe), .fe(fe), .rx_fifo_error(rx_fifo_error),
    .rx_level(rx_level), .rda_int(rda_int), .cti_int(cti_int)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic check_state(input string tag);
    logic [9:0] h;
    h = (sb.size() != 0) ? sb[0] : 10'h000;
    check({tag, ".level"}, 32'(rx_level), 32'(sb.size()));
    check({tag, ".dr"},    32'(dr),       32'(sb.size() != 0));
    check({tag, ".data"},  32'(rbr_data), 32'(h[9:2]));
    check({tag, ".oe"},    32'(oe),       32'(exp_oe));
  endtask

  task automatic push(input logic [7:0] d, input logic p, input logic f);
    rsr_data = d; parity_error = p; frame_error = f; rx_push = 1'b1;
    cyc();
    rx_push = 1'b0; parity_error = 1'b0; frame_error = 1'b0;
    if (fifo_en) begin
      if (sb.size() < 16) sb.push_back({d, p, f});
      else exp_oe = 1'b1;
    end else begin
      if (sb.size() == 0) sb.push_back({d, p, f});
      else begin sb[0] = {d, p, f}; exp_oe = 1'b1; end
    end
  endtask

  task automatic pop(input string tag);
    logic [9:0] h;
    h = sb[0];
    check({tag, ".head"}, 32'(rbr_data), 32'(h[9:2]));
    check({tag, ".pe"},   32'(pe),       32'(h[1]));
    check({tag, ".fe"},   32'(fe),       32'(h[0]));
    rbr_rd = 1'b1;
    cyc();
    rbr_rd = 1'b0;
    void'(sb.pop_front());
  endtask

  task automatic lsr_read();
    lsr_rd = 1'b1;
    cyc();
    lsr_rd = 1'b0;
    exp_oe = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".rbr"},  32'(rbr_data),      32'h0);
    check({tag, ".dr"},   32'(dr),            32'h0);
    check({tag, ".oe"},   32'(oe),            32'h0);
    check({tag, ".pe"},   32'(pe),            32'h0);
    check({tag, ".fe"},   32'(fe),            32'h0);
    check({tag, ".rfe"},  32'(rx_fifo_error), 32'h0);
    check({tag, ".lvl"},  32'(rx_level),      32'h0);
    check({tag, ".rda"},  32'(rda_int),       32'h0);
    check({tag, ".cti"},  32'(cti_int),       32'h0);
  endtask

  initial begin
    preset = 1'b1; rx_push = 1'b0; rsr_data = 8'h00; parity_error = 1'b0;
    frame_error = 1'b0; fifo_en = 1'b0; fifo_clr = 1'b0; rtl = 2'b00;
    rbr_rd = 1'b0; lsr_rd = 1'b0; char_tick = 1'b0;
    cyc(); cyc();
    check_all_zero("reset");
    preset = 1'b0;

    // Fill to 16 in FIFO mode, overrun, simultaneous push/pop at full
    fifo_en = 1'b1; cyc(); cyc();
    for (int i = 1; i <= 16; i++) push(8'(i), 1'b0, 1'b0);
    check_state("fill");
    check("fill.rda", 32'(rda_int), 32'h1);
    push(8'hAA, 1'b0, 1'b0);
    check_state("ovr");
    lsr_read();
    check_state("lsr");
    check("pp.head", 32'(rbr_data), 32'h01);
    rsr_data = 8'hBB; rx_push = 1'b1; rbr_rd = 1'b1;
    cyc();
    rx_push = 1'b0; rbr_rd = 1'b0;
    void'(sb.pop_front()); sb.push_back({8'hBB, 2'b00});
    check_state("pushpop");
    while (sb.size() != 0) pop("drain");
    check_state("empty");

    // Error flags and errored-entry tracking
    push(8'h11, 1'b0, 1'b1);
    push(8'h22, 1'b0, 1'b0);
    check("err.fe",  32'(fe),            32'h1);
    check("err.rfe", 32'(rx_fifo_error), 32'h1);
    pop("err1");
    check("err.fe2",  32'(fe),            32'h0);
    check("err.rfe2", 32'(rx_fifo_error), 32'h0);
    pop("err2");
    push(8'h33, 1'b1, 1'b0);
    check("err.pe",  32'(pe),            32'h1);
    check("err.rfe3", 32'(rx_fifo_error), 32'h1);
    pop("err3");
    check("err.rfe4", 32'(rx_fifo_error), 32'h0);

    // Trigger level 8 and clear with a same-cycle push
    rtl = 2'b10;
    for (int i = 0; i < 7; i++) push(8'(8'h40 + i), 1'b0, 1'b0);
    check("trig7.rda", 32'(rda_int), 32'h0);
    push(8'h47, 1'b0, 1'b0);
    check("trig8.rda", 32'(rda_int), 32'h1);
    fifo_clr = 1'b1; rx_push = 1'b1; rsr_data = 8'h99;
    cyc();
    fifo_clr = 1'b0; rx_push = 1'b0;
    sb.delete();
    check_state("clr");
    check("clr.rda", 32'(rda_int), 32'h0);

    // Holding mode: second push overwrites
    fifo_en = 1'b0; cyc(); cyc();
    push(8'h55, 1'b0, 1'b0);
    push(8'h66, 1'b0, 1'b0);
    check_state("hold");
    check("hold.rda", 32'(rda_int),       32'h1);
    check("hold.rfe", 32'(rx_fifo_error), 32'h0);
    push(8'h77, 1'b0, 1'b1);
    check("hold.fe",  32'(fe),            32'h1);
    check("hold.rfe2", 32'(rx_fifo_error), 32'h0);
    lsr_read();
    pop("hold");
    check_state("hold.empty");

    // Character timeout
    fifo_en = 1'b1; rtl = 2'b11; cyc(); cyc();
    push(8'h42, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check("tmo3.cti", 32'(cti_int), 32'h0);
      char_tick = 1'b1; cyc(); char_tick = 1'b0; cyc();
    end
`ifdef UART_RX_TIMEOUT_EN
    check("tmo4.cti", 32'(cti_int), 32'h1);
`else
    check("tmo4.cti", 32'(cti_int), 32'h0);
`endif
    pop("tmo");
    check("tmo.cti.rd", 32'(cti_int), 32'h0);

    // Reset in the middle of a push with oe set
    for (int i = 0; i < 17; i++) push(8'(8'h80 + i), 1'b1, 1'b0);
    check_state("pre_rst");
    preset = 1'b1; rx_push = 1'b1; rsr_data = 8'hEE;
    cyc();
    rx_push = 1'b0;
    check_all_zero("midrst");
    preset = 1'b0;
    cyc();
    check_all_zero("postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
